// File: rtl/fib_seq_engine_if.sv
// Request/response bundle for fib_seq_engine: operands and start in,
// status and result out.
interface fib_seq_engine_if #(
  parameter int unsigned N_W   = 4,
  parameter int unsigned OUT_W = 16
);
  logic             start;
  logic [N_W-1:0]   n;
  logic [OUT_W-1:0] seed_a;
  logic [OUT_W-1:0] seed_b;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] result;
  logic             overflow;

  modport master (
    output start, n, seed_a, seed_b,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, n, seed_a, seed_b,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/fib_seq_engine.sv
// Iterative seeded Fibonacci-term engine: one addition per clock, modulo
// 2^OUT_W, with a sticky carry-out flag reported alongside the result.
module fib_seq_engine #(
  parameter int unsigned N_W   = 4,
  parameter int unsigned OUT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fib_seq_engine_if.slave   bus_if
);

  typedef enum logic {IDLE, CALC} state_t;

  localparam logic [N_W-1:0] ONE = N_W'(1);
  localparam logic [N_W-1:0] TWO = N_W'(2);

  state_t           state_q, state_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [N_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0] a_q, a_d;
  logic [OUT_W-1:0] b_q, b_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic [OUT_W:0]   sum;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      ovf_acc_q  <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      ovf_acc_q  <= ovf_acc_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // Carries accumulate privately and are published only at completion, so
  // the visible overflow holds across a new start while still being cleared
  // per computation.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    ovf_acc_d  = ovf_acc_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus_if.start) begin
          n_d       = bus_if.n;
          a_d       = bus_if.seed_a;
          b_d       = bus_if.seed_b;
          cnt_d     = (bus_if.n > TWO) ? bus_if.n - TWO : '0;
          ovf_acc_d = 1'b0;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          a_d   = b_q;
          b_d   = sum[OUT_W-1:0];
          cnt_d = cnt_q - ONE;
          if (sum[OUT_W]) ovf_acc_d = 1'b1;
        end else begin
          result_d   = (n_q <= ONE) ? a_q : b_q;
          overflow_d = ovf_acc_q;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_if.busy     = (state_q == CALC);
  assign bus_if.done     = done_q;
  assign bus_if.result   = result_q;
  assign bus_if.overflow = overflow_q;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Bench for fib_seq_engine: a 16-bit and an 8-bit instance run the same
// stimulus and are compared against a plain-arithmetic sequence model.
module tb_fib_seq_engine;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  longint exp_r16, exp_r8;
  bit     exp_o16, exp_o8;

  fib_seq_engine_if #(.N_W(4), .OUT_W(16)) if16 ();
  fib_seq_engine_if #(.N_W(4), .OUT_W(8))  if8 ();

  fib_seq_engine #(.N_W(4), .OUT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus_if(if16));
  fib_seq_engine #(.N_W(4), .OUT_W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus_if(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // T(0)=T(1)=sa, T(2)=sb, T(k)=T(k-1)+T(k-2), all sums reduced mod 2^w.
  function automatic void model(input int n, input longint sa, input longint sb,
                                input int w, output longint res, output bit ovf);
    longint mask, a, b, s;
    mask = (64'd1 << w) - 1;
    a = sa & mask;
    b = sb & mask;
    ovf = 1'b0;
    for (int k = 3; k <= n; k++) begin
      s = a + b;
      if (s > mask) ovf = 1'b1;
      a = b;
      b = s & mask;
    end
    res = (n <= 1) ? a : b;
  endfunction

  task automatic drive(input bit st, input int n, input int sa, input int sb);
    if16.start = st; if16.n = 4'(n); if16.seed_a = 16'(sa); if16.seed_b = 16'(sb);
    if8.start  = st; if8.n  = 4'(n); if8.seed_a  = 8'(sa);  if8.seed_b  = 8'(sb);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle with start low.
  task automatic run(input int n, input int sa, input int sb, input bit poke);
    longint r16, r8;
    bit     o16, o8;
    int     edges, busyc, lim;
    model(n, sa, sb, 16, r16, o16);
    model(n, sa, sb, 8,  r8,  o8);
    lim = ((n > 2) ? n - 2 : 0) + 2;
    drive(1'b1, n, sa, sb);
    @(negedge clk);
    edges = 1;
    drive(1'b0, $urandom_range(0, 15), $urandom, $urandom);
    check("hold_result16", if16.result, exp_r16);
    check("hold_ovf16", if16.overflow, exp_o16);
    check("hold_result8", if8.result, exp_r8);
    check("busy_after_start", if16.busy, 1);
    busyc = 0;
    while (!if16.done && edges < 40) begin
      if (if16.busy) busyc++;
      if (poke && edges == 2) drive(1'b1, $urandom_range(0, 15), $urandom, $urandom);
      else                    drive(1'b0, $urandom_range(0, 15), $urandom, $urandom);
      @(negedge clk);
      edges++;
    end
    drive(1'b0, n, sa, sb);
    check("latency", edges, lim);
    check("busy_cycles", busyc, lim - 1);
    check("done16", if16.done, 1);
    check("done8", if8.done, 1);
    check("busy_in_done", if16.busy, 0);
    check("result16", if16.result, r16);
    check("ovf16", if16.overflow, o16);
    check("result8", if8.result, r8);
    check("ovf8", if8.overflow, o8);
    exp_r16 = r16; exp_o16 = o16;
    exp_r8  = r8;  exp_o8  = o8;
  endtask

  initial begin
    int n, gap;
    n_checks = 0;
    n_fail   = 0;
    exp_r16 = 0; exp_r8 = 0; exp_o16 = 0; exp_o8 = 0;
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 0);
    #1;
    check("rst_busy", if16.busy, 0);
    check("rst_done", if16.done, 0);
    check("rst_result16", if16.result, 0);
    check("rst_ovf8", if8.overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(15, 1, 1, 1'b0);
    check("r15_16", if16.result, 610);
    @(negedge clk);
    check("done_one_cycle", if16.done, 0);
    run(0, 1, 1, 1'b0);
    run(1, 1, 1, 1'b0);
    run(2, 1, 1, 1'b0);
    run(5, 2, 1, 1'b0);
    check("r5_seed21", if16.result, 7);
    run(13, 1, 1, 1'b0);
    check("r13_8", if8.result, 233);
    run(14, 1, 1, 1'b0);
    check("r14_8", if8.result, 121);
    check("r14_ovf8", if8.overflow, 1);
    run(3, 1, 1, 1'b0);
    check("r3_ovf8_cleared", if8.overflow, 0);
    @(negedge clk);
    run(10, 1, 1, 1'b1);
    check("r10_poked", if16.result, 55);
    @(negedge clk);
    check("no_second_done", if16.done, 0);
    check("no_second_busy", if16.busy, 0);

    // Abort a computation with reset, then restart.
    drive(1'b1, 12, 1, 1);
    @(negedge clk);
    drive(1'b0, 12, 1, 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", if16.busy, 0);
    check("abort_result16", if16.result, 0);
    check("abort_result8", if8.result, 0);
    check("abort_ovf", if16.overflow, 0);
    exp_r16 = 0; exp_r8 = 0; exp_o16 = 0; exp_o8 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", if16.done | if8.done, 0);
    end
    run(6, 1, 1, 1'b0);
    check("r6_after_reset", if16.result, 8);

    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(0, 15);
      run(n, $urandom, $urandom, (n >= 4) && $urandom_range(0, 1) == 1);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_seq_engine.md
FIB_SEQ_ENGINE -- requirements
Module: fib_seq_engine

Interface
REQ-001 Parameter N_W, default 4, width of the term index n.
REQ-002 Parameter OUT_W, default 16, width of the seeds, the internal terms and result.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 n  input  N_W  index of the requested term; sampled with an accepted start.
REQ-007 seed_a  input  OUT_W  term T(1); sampled with an accepted start.
REQ-008 seed_b  input  OUT_W  term T(2); sampled with an accepted start.
REQ-009 busy  output  1  high while the block is computing.
REQ-010 done  output  1  one-cycle pulse; result and overflow are valid in this cycle.
REQ-011 result  output  OUT_W  computed term, taken modulo 2^OUT_W.
REQ-012 overflow  output  1  set if any addition in the computation carried out of OUT_W bits.

Function
REQ-013 Sequence definition:
- T(0) = T(1) = seed_a.
- T(2) = seed_b.
- T(k) = T(k-1) + T(k-2) for k >= 3.
- With seeds 1,1 the block returns 1 for n <= 2.
REQ-014 The state machine has two states, IDLE and CALC.
REQ-015 In IDLE with start=1, on the clock edge the block shall:
- latch n, seed_a and seed_b;
- load a <= seed_a and b <= seed_b;
- load the iteration counter cnt <= (n > 2) ? n-2 : 0;
- clear overflow;
- enter CALC.
REQ-016 In CALC with cnt != 0, on each edge the block shall:
- set a <= b and b <= (a+b) mod 2^OUT_W;
- decrement cnt;
- set overflow if the carry out of a+b is 1.
REQ-017 In CALC with cnt == 0, on the edge the block shall:
- set result <= (latched n <= 1) ? a : b;
- assert done for exactly one cycle;
- return to IDLE.
REQ-018 Latency: with start accepted at edge E0, done is high in the cycle following edge E0 + max(n-2,0) + 1.
REQ-019 busy = 1 exactly while in CALC; busy is 0 in the done cycle.
REQ-020 start while busy is ignored and does not alter latched operands.
REQ-021 start in the done cycle is accepted, because the block is already in IDLE, so back-to-back operation is allowed.
REQ-022 result and overflow hold their values from the last completion until the next done, and do not change on start.
REQ-023 Changes on n, seed_a or seed_b after acceptance have no effect on the running computation.
REQ-024 Arithmetic wraps modulo 2^OUT_W; after overflow is set, later additions continue on the wrapped values and overflow stays 1.
REQ-025 n = 2^N_W - 1 (maximum index) requires 2^N_W - 3 iterations; cnt shall be N_W bits wide and shall not wrap.

Reset
REQ-026 While rst_n = 0, independent of clk:
- state = IDLE;
- busy = 0, done = 0, result = 0, overflow = 0;
- a, b and cnt are cleared.
REQ-027 Reset asserted mid-computation aborts it without asserting done.
REQ-028 After rst_n rises, the first start is accepted normally.

Verification
REQ-029 Defaults with seeds 1,1:
- n=15 -> result=610, overflow=0;
- done appears 15 cycles after the start edge;
- busy is high for 14 cycles.
REQ-030 Seeds 1,1, n=0, n=1 and n=2 -> result=1 each, with done one cycle after CALC entry (no iterations).
REQ-031 Seeds 2,1, n=5 -> result=7 (sequence 2,1,3,4,7), overflow=0.
REQ-032 OUT_W=8, seeds 1,1:
- n=13 -> result=233, overflow=0;
- n=14 -> result=121 (377 mod 256), overflow=1;
- a following run with n=3 clears overflow -> result=2, overflow=0.
REQ-033 start n=10, second start with n=3 pulsed while busy -> single done with result=55, and no second computation.
REQ-034 rst_n pulled low mid-run of n=12 -> done is never asserted and outputs read 0; then start n=6 -> result=8.
